// File: rtl/matmul_engine_if.sv
// Memory-master bus of the matrix-multiply engine: one request channel shared by
// operand reads and result writes, with a one-cycle read-data return.
interface matmul_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ACC_W-1:0]  mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/matmul_engine.sv
// Matrix-multiply coprocessor: C = A x B with runtime X/Y/Z, operands fetched from
// and results written to data memory through a ready-qualified request bus.
module matmul_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_x,
  input  logic [DIM_W-1:0]  dim_y,
  input  logic [DIM_W-1:0]  dim_z,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  matmul_engine_if.master   mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t             r_state;
  logic [DIM_W-1:0]   r_dim_x, r_dim_y, r_dim_z;
  logic [DIM_W-1:0]   r_i, r_j, r_k;
  logic [ADDR_W-1:0]  r_b_base;
  logic [ADDR_W-1:0]  r_a_row, r_a_ptr;
  logic [ADDR_W-1:0]  r_b_col, r_b_ptr;
  logic [ADDR_W-1:0]  r_c_ptr;
  logic [DATA_W-1:0]  r_a_reg;
  logic               r_b_first;
  logic [ACC_W-1:0]   r_acc;
  logic               r_err;

  logic [2*DATA_W-1:0] w_prod;
  logic [ADDR_W-1:0]   w_next_a_row;
  logic                w_j_last, w_k_last, w_i_last, w_zero_dim;

  assign w_prod       = {{DATA_W{1'b0}}, r_a_reg} * {{DATA_W{1'b0}}, mem.mem_rdata};
  assign w_next_a_row = r_a_row + ADDR_W'(r_dim_y);
  assign w_j_last     = (r_j == r_dim_y - DIM_W'(1));
  assign w_k_last     = (r_k == r_dim_z - DIM_W'(1));
  assign w_i_last     = (r_i == r_dim_x - DIM_W'(1));
  assign w_zero_dim   = (dim_x == '0) || (dim_y == '0) || (dim_z == '0);

  // Row pointer steps by Y per C row, column pointer by 1 per C column; the read
  // pointers then walk along A's row (+1) and down B's column (+Z) without multipliers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_dim_x   <= '0;
      r_dim_y   <= '0;
      r_dim_z   <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_b_base  <= '0;
      r_a_row   <= '0;
      r_a_ptr   <= '0;
      r_b_col   <= '0;
      r_b_ptr   <= '0;
      r_c_ptr   <= '0;
      r_a_reg   <= '0;
      r_b_first <= 1'b0;
      r_acc     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dim_x  <= dim_x;
            r_dim_y  <= dim_y;
            r_dim_z  <= dim_z;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_b_base <= b_base;
            r_a_row  <= a_base;
            r_a_ptr  <= a_base;
            r_b_col  <= b_base;
            r_b_ptr  <= b_base;
            r_c_ptr  <= c_base;
            r_acc    <= '0;
            r_err    <= w_zero_dim;
            r_state  <= w_zero_dim ? S_DONE : S_RD_A;
          end
        end
        S_RD_A: begin
          if (mem.mem_ready) begin
            r_b_first <= 1'b1;
            r_state   <= S_RD_B;
          end
        end
        S_RD_B: begin
          // A's data returns only in the first RD_B cycle; later stall cycles must not overwrite it.
          if (r_b_first) begin
            r_a_reg   <= mem.mem_rdata;
            r_b_first <= 1'b0;
          end
          if (mem.mem_ready) r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (w_j_last) begin
            r_state <= S_WRITE;
          end else begin
            r_j     <= r_j + DIM_W'(1);
            r_a_ptr <= r_a_ptr + ADDR_W'(1);
            r_b_ptr <= r_b_ptr + ADDR_W'(r_dim_z);
            r_state <= S_RD_A;
          end
        end
        S_WRITE: begin
          if (mem.mem_ready) begin
            r_acc   <= '0;
            r_j     <= '0;
            r_c_ptr <= r_c_ptr + ADDR_W'(1);
            if (w_k_last) begin
              r_k     <= '0;
              r_b_col <= r_b_base;
              r_b_ptr <= r_b_base;
              r_a_row <= w_next_a_row;
              r_a_ptr <= w_next_a_row;
              if (w_i_last) begin
                r_state <= S_DONE;
              end else begin
                r_i     <= r_i + DIM_W'(1);
                r_state <= S_RD_A;
              end
            end else begin
              r_k     <= r_k + DIM_W'(1);
              r_b_col <= r_b_col + ADDR_W'(1);
              r_b_ptr <= r_b_col + ADDR_W'(1);
              r_a_ptr <= r_a_row;
              r_state <= S_RD_A;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.mem_rd_en = 1'b0;
    mem.mem_wr_en = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      S_RD_A: begin
        mem.mem_rd_en = 1'b1;
        mem.mem_addr  = r_a_ptr;
      end
      S_RD_B: begin
        mem.mem_rd_en = 1'b1;
        mem.mem_addr  = r_b_ptr;
      end
      S_WRITE: begin
        mem.mem_wr_en = 1'b1;
        mem.mem_addr  = r_c_ptr;
        mem.mem_wdata = r_acc;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = r_err;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: table of matrix commands with hand-computed C,
// plus zero-dimension, stall, reset-abort and accumulator-wrap sequences.
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dim_x = '0, dim_y = '0, dim_z = '0;
  logic [15:0] a_base = '0, b_base = '0, c_base = '0;
  logic        busy, done, err;

  logic        start2 = 1'b0;
  logic        busy2, done2, err2;

  matmul_engine_if #(.DATA_W(8), .ACC_W(24), .ADDR_W(16)) if1 ();
  matmul_engine_if #(.DATA_W(8), .ACC_W(16), .ADDR_W(16)) if2 ();

  matmul_engine #(.DATA_W(8), .ACC_W(24), .ADDR_W(16), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dim_x(dim_x), .dim_y(dim_y), .dim_z(dim_z),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .err(err), .mem(if1)
  );

  matmul_engine #(.DATA_W(8), .ACC_W(16), .ADDR_W(16), .DIM_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start2),
    .dim_x(8'd1), .dim_y(8'd2), .dim_z(8'd1),
    .a_base(16'h0100), .b_base(16'h0200), .c_base(16'h0300),
    .busy(busy2), .done(done2), .err(err2), .mem(if2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  bit stall_en = 1'b0;

  logic [7:0] mem [0:255];
  logic [15:0] wr_addr_q [$];
  logic [23:0] wr_data_q [$];
  logic [15:0] wr2_data_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Memory models: read data appears one cycle after an accepted read, junk otherwise.
  always @(posedge clk) begin
    if (if1.mem_rd_en && if1.mem_ready) if1.mem_rdata <= mem[if1.mem_addr[7:0]];
    else                                if1.mem_rdata <= 8'hA5;
    if2.mem_rdata <= (if2.mem_rd_en && if2.mem_ready) ? 8'hFF : 8'h00;
  end

  initial begin
    if1.mem_ready = 1'b1;
    if2.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if1.mem_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  logic        prev_stall = 1'b0;
  logic        prev_rd, prev_wr;
  logic [15:0] prev_addr;
  logic [23:0] prev_wdata;

  always @(negedge clk) begin
    if (if1.mem_rd_en || if1.mem_wr_en) req_cnt++;
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (if1.mem_rd_en && if1.mem_wr_en) chk("rd_wr_exclusive", 1, 0);
      if (prev_stall) begin
        chk("stall_hold_rd", if1.mem_rd_en, prev_rd);
        chk("stall_hold_wr", if1.mem_wr_en, prev_wr);
        chk("stall_hold_addr", if1.mem_addr, prev_addr);
        chk("stall_hold_wdata", if1.mem_wdata, prev_wdata);
      end
      if ((if1.mem_rd_en || if1.mem_wr_en) && !if1.mem_ready) stall_cnt++;
      if (if1.mem_wr_en && if1.mem_ready) begin
        wr_addr_q.push_back(if1.mem_addr);
        wr_data_q.push_back(if1.mem_wdata);
      end
      prev_stall <= (if1.mem_rd_en || if1.mem_wr_en) && !if1.mem_ready;
      prev_rd    <= if1.mem_rd_en;
      prev_wr    <= if1.mem_wr_en;
      prev_addr  <= if1.mem_addr;
      prev_wdata <= if1.mem_wdata;
    end
    if (rst && if2.mem_wr_en && if2.mem_ready) wr2_data_q.push_back(if2.mem_wdata);
  end

  typedef struct packed {
    logic [7:0]        dx, dy, dz;
    logic [15:0]       ab, bb, cb;
    logic [0:5][7:0]   a;
    logic [0:5][7:0]   b;
    logic [0:5][15:0]  c;
    logic [7:0]        done_at;
  } vec_t;

  vec_t vt [5];

  task automatic load_mem(input vec_t v);
    logic [15:0] ad;
    for (int n = 0; n < 256; n++) mem[n] = 8'h00;
    for (int n = 0; n < int'(v.dx) * int'(v.dy); n++) begin
      ad = v.ab + 16'(n);
      mem[ad[7:0]] = v.a[n];
    end
    for (int n = 0; n < int'(v.dy) * int'(v.dz); n++) begin
      ad = v.bb + 16'(n);
      mem[ad[7:0]] = v.b[n];
    end
  endtask

  task automatic run_vec(input vec_t v, input bit stall, input bit poke);
    int m;
    int busy_n;
    int nw;
    bit got;
    load_mem(v);
    wr_addr_q.delete();
    wr_data_q.delete();
    stall_cnt = 0;
    stall_en = stall;
    @(negedge clk);
    start = 1'b1;
    dim_x = v.dx; dim_y = v.dy; dim_z = v.dz;
    a_base = v.ab; b_base = v.bb; c_base = v.cb;
    m = 0; busy_n = 0; got = 1'b0;
    while (m < 400 && !got) begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        start = 1'b0;
        chk("err_clear_on_start", err, 0);
      end
      if (poke && m == 5) begin
        start = 1'b1;
        dim_x = 8'd1; dim_y = 8'd1; dim_z = 8'd1; c_base = 16'h00F0;
      end
      if (poke && m == 6) start = 1'b0;
      if (busy) busy_n++;
      if (done) got = 1'b1;
    end
    stall_en = 1'b0;
    chk("done_seen", got, 1);
    chk("done_cycle", m, int'(v.done_at) + stall_cnt);
    chk("busy_cycles", busy_n, m);
    nw = int'(v.dx) * int'(v.dz);
    chk("n_writes", wr_addr_q.size(), nw);
    for (int n = 0; n < nw && n < wr_addr_q.size(); n++) begin
      chk("wr_addr", wr_addr_q[n], 16'(v.cb + 16'(n)));
      chk("wr_data", wr_data_q[n], v.c[n]);
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int m;
    bit got;

    vt[0] = '{dx:8'd2, dy:8'd2, dz:8'd2, ab:16'h0010, bb:16'h0020, cb:16'h0030,
              a:{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0},
              b:{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0},
              c:{16'd19, 16'd22, 16'd43, 16'd50, 16'd0, 16'd0}, done_at:8'd29};
    vt[1] = '{dx:8'd2, dy:8'd3, dz:8'd1, ab:16'h0040, bb:16'h0050, cb:16'h0060,
              a:{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
              b:{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0},
              c:{16'd6, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0}, done_at:8'd21};
    vt[2] = '{dx:8'd1, dy:8'd1, dz:8'd3, ab:16'h0070, bb:16'h0078, cb:16'h0080,
              a:{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
              b:{8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0},
              c:{16'd14, 16'd21, 16'd28, 16'd0, 16'd0, 16'd0}, done_at:8'd13};
    vt[3] = '{dx:8'd3, dy:8'd1, dz:8'd2, ab:16'h0090, bb:16'h0098, cb:16'h00A0,
              a:{8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0},
              b:{8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0},
              c:{16'd20, 16'd40, 16'd30, 16'd60, 16'd40, 16'd80}, done_at:8'd25};
    vt[4] = '{dx:8'd1, dy:8'd1, dz:8'd2, ab:16'hFFFE, bb:16'hFFFF, cb:16'hFFFF,
              a:{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
              b:{8'd255, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
              c:{16'd51000, 16'd200, 16'd0, 16'd0, 16'd0, 16'd0}, done_at:8'd9};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", if1.mem_rd_en, 0);
    chk("rst_wr_en", if1.mem_wr_en, 0);
    chk("rst_addr", if1.mem_addr, 0);
    chk("rst_wdata", if1.mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_vec(vt[t], 1'b0, 1'b0);

    // zero dimension: immediate done with err, no memory traffic
    req_cnt = 0;
    @(negedge clk);
    start = 1'b1; dim_x = 8'd2; dim_y = 8'd0; dim_z = 8'd2;
    @(negedge clk);
    start = 1'b0;
    chk("zd_done", done, 1);
    chk("zd_err", err, 1);
    chk("zd_busy", busy, 1);
    @(negedge clk);
    chk("zd_done_pulse", done, 0);
    chk("zd_busy_after", busy, 0);
    chk("zd_err_sticky", err, 1);
    chk("zd_no_requests", req_cnt, 0);
    run_vec(vt[2], 1'b0, 1'b0);

    run_vec(vt[0], 1'b1, 1'b0);

    // reset during the second MAC, then a full command with a start pulse while busy
    load_mem(vt[0]);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1;
    dim_x = 8'd2; dim_y = 8'd2; dim_z = 8'd2;
    a_base = 16'h0010; b_base = 16'h0020; c_base = 16'h0030;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", if1.mem_rd_en, 0);
    chk("abort_wr_en", if1.mem_wr_en, 0);
    chk("abort_addr", if1.mem_addr, 0);
    chk("abort_done", done, 0);
    req_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_requests", req_cnt, 0);
    chk("abort_no_writes", wr_addr_q.size(), 0);
    run_vec(vt[0], 1'b0, 1'b1);

    // 16-bit accumulator wrap: 255*255 + 255*255 mod 65536
    wr2_data_q.delete();
    @(negedge clk);
    start2 = 1'b1;
    m = 0; got = 1'b0;
    while (m < 100 && !got) begin
      @(negedge clk);
      m++;
      start2 = 1'b0;
      if (done2) got = 1'b1;
    end
    chk("wrap_done_seen", got, 1);
    chk("wrap_done_cycle", m, 8);
    chk("wrap_n_writes", wr2_data_q.size(), 1);
    if (wr2_data_q.size() > 0) chk("wrap_data", wr2_data_q[0], 64514);
    chk("wrap_err", err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised hardware matrix-multiply engine: computes C = A × B for runtime dimensions (A is X×Y, B is Y×Z, C is X×Z). It fetches operands from data memory, multiply-accumulates in a dedicated accumulator, and writes C back. It sits beside the control unit as a memory-mastering coprocessor with a start/done handshake. It replaces the instruction-sequenced X/Y/Z and STXY/STYZ/STXZ loop with a single-command block.

## Interface
- DATA_W, 8: element width of A and B (unsigned).
- ACC_W, 24: accumulator and C element width.
- ADDR_W, 16: memory address width.
- DIM_W, 8: width of each dimension input.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- dim_x, dim_y, dim_z  in  DIM_W each  matrix dimensions X, Y, Z.
- a_base, b_base, c_base  in  ADDR_W each  row-major base addresses.
- mem_addr  out  ADDR_W  read or write address.
- mem_rd_en  out  1  read request.
- mem_wr_en  out  1  write request.
- mem_wdata  out  ACC_W  C element being written.
- mem_ready  in  1  memory accepts the current request this cycle.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after read accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  zero-dimension command flag; sticky until the next accepted start.

## Operation
- States: IDLE, RD_A, RD_B, MAC, WRITE, DONE.
- IDLE:
  - start=1 latches dims and bases, clears i/j/k counters, accumulator and err.
  - If any dim is 0: err←1, go to DONE, with no memory access.
  - Otherwise go to RD_A.
- RD_A: mem_rd_en=1, mem_addr=a_base+i·Y+j. On accept (mem_ready=1) go to RD_B; otherwise hold.
- RD_B:
  - On its first cycle, a_reg←mem_rdata.
  - mem_rd_en=1, mem_addr=b_base+j·Z+k. On accept go to MAC; otherwise hold, and a_reg is not reloaded.
- MAC:
  - acc←acc + a_reg·mem_rdata. The product is 2·DATA_W bits, zero-extended or truncated to ACC_W; the sum wraps modulo 2^ACC_W.
  - If j=Y−1 go to WRITE; otherwise j←j+1 and go to RD_A.
- WRITE:
  - mem_wr_en=1, mem_addr=c_base+i·Z+k, mem_wdata=acc.
  - On accept: acc←0, j←0, then advance k (0…Z−1) and, on k wrap, i (0…X−1).
  - After the final element (i=X−1, k=Z−1) go to DONE; otherwise go to RD_A.
  - Hold while mem_ready=0.
- DONE: done=1 for one cycle, then IDLE.
- Address generation:
  - Use incremental row/column pointers, not multipliers.
  - Address arithmetic wraps modulo 2^ADDR_W.
- mem_rd_en and mem_wr_en are never high together.
- mem_addr and mem_wdata are don't-care when no request is asserted; drive them to 0.
- start while busy=1 is ignored. Dims and bases are only sampled at an accepted start.
- Reset mid-operation: immediate return to IDLE; all outputs and counters go to 0; no further memory requests.

## Timing
- Reset values: mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wdata=0, busy=0, done=0, err=0, state IDLE.
- All outputs are registered or decoded from registered state only. mem_ready and mem_rdata have no combinational path to any output.
- Start accepted at cycle T0. First RD_A is at T0+1.
- With mem_ready held high:
  - Each C element takes 3·Y+1 cycles.
  - The last WRITE is at T0 + X·Z·(3·Y+1).
  - done pulses on the following cycle.
- Zero-dimension command: done and err are high at T0+1; busy is high for that cycle only.
- Each cycle with mem_ready=0 during a request adds exactly one cycle of latency.

## Test plan
- 2×2×2: A=[[1,2],[3,4]] at a_base=0x10, B=[[5,6],[7,8]] at b_base=0x20, c_base=0x30, ready=1 → writes 19, 22, 43, 50 to 0x30–0x33 in order; done at T0+29; busy high for T0+1…T0+29.
- 2×3×1: A=[[1,2,3],[4,5,6]], B=[[1],[1],[1]] → writes C=[6,15]; done at T0+21.
- Wrap: ACC_W=16, 1×2×1, all elements 255 → writes 64514 (130050 mod 65536).
- dim_y=0 with start → no rd/wr requests; done=err=1 at T0+1. A following valid start clears err.
- Random mem_ready stalls (~50% low) on the 2×2×2 case → same C values and addresses. Each request holds stable while stalled; completion is delayed by exactly the number of stall cycles.
- rst low during the second MAC, then a new start → outputs 0 immediately, no spurious writes, and a correct full result on the new command; start pulsed while busy has no effect.
